proof_addsub_seq: RTL and testbench
===================================

PROOF_ADDSUB_SEQ -- requirements
Module: proof_addsub_seq

Interface
REQ-001 SHALL have parameter TMO_CYC, default 15: engine-response timeout in cycles, counted from the cycle after eng_dstr_o.
REQ-002 SHALL have port clk_i  input  1  clock; all state on rising edge.
REQ-003 SHALL have port arst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports cmd_vld_i input 1, cmd_rdy_o output 1  command handshake.
REQ-005 SHALL have ports cmd_mode_i input 1 (0 add, 1 sub), cmd_sa_i/cmd_sb_i/cmd_dst_i input 2 each  source A, source B and destination register indices.
REQ-006 SHALL have ports wr_en_i input 1, wr_addr_i input 2, wr_data_i input 256  host register load.
REQ-007 SHALL have ports rd_addr_i input 2, rd_data_o output 256  combinational host register read.
REQ-008 SHALL have ports modp_i input 256  modulus; eng_modp_o output 256  modp_i passed through unregistered.
REQ-009 SHALL have ports eng_dstr_o output 1, eng_mode_o output 1, eng_data_o output 256, eng_datb_o output 256  engine start and operands.
REQ-010 SHALL have ports eng_dend_i input 1, eng_datc_i input 256  engine completion and result.
REQ-011 SHALL have ports done_o output 1  per-command completion pulse; busy_o output 1; err_o output 1  sticky timeout; err_clr_i input 1; chk_err_o output 1  sticky result-check error.

Function
REQ-012 SHALL hold a 4x256-bit register file, written by host loads and command writeback.
REQ-013 SHALL buffer commands in a 2-entry FIFO; cmd_rdy_o = FIFO not full; a command is accepted on cmd_vld_i & cmd_rdy_o.
REQ-014 SHALL accept a push into a full FIFO that pops in the same cycle.
REQ-015 SHALL run FSM IDLE -> ISSUE -> WAIT -> WB -> IDLE; IDLE->ISSUE when FIFO is non-empty (pop occurs on this transition).
REQ-016 In ISSUE, SHALL drive eng_dstr_o=1 for exactly one cycle with eng_mode_o=mode, eng_data_o=reg[sa] and eng_datb_o=reg[sb].
REQ-017 SHALL hold eng_mode_o, eng_data_o and eng_datb_o stable from ISSUE until leaving WAIT, and SHALL drive them to 0 in IDLE.
REQ-018 In WAIT, on eng_dend_i SHALL latch eng_datc_i and go to WB; eng_dend_i outside WAIT SHALL be ignored.
REQ-019 In WB, SHALL write the latched result to reg[dst] and pulse done_o for one cycle.
REQ-020 Engine latency of 3 cycles SHALL give 6 cycles from pop to done_o; back-to-back commands SHALL incur no extra idle cycle beyond IDLE.
REQ-021 When no eng_dend_i has arrived within TMO_CYC cycles in WAIT, SHALL set err_o, pulse done_o, skip writeback and go to IDLE.
REQ-022 err_clr_i SHALL clear err_o and chk_err_o; a set in the same cycle SHALL win over a clear.
REQ-023 A host write and a WB write to the same address in the same cycle SHALL resolve with WB winning; writes to different addresses SHALL both occur.
REQ-024 ISSUE operand reads SHALL see register values before any same-cycle write, so sa = sb = dst is legal.
REQ-025 busy_o SHALL be 1 when the FSM is not in IDLE or the FIFO is non-empty.

Reset
REQ-026 On arst_ni low, SHALL immediately force: FSM=IDLE, FIFO empty, registers=0, timeout counter=0, and all outputs 0 except cmd_rdy_o=1, rd_data_o=0 and eng_modp_o=modp_i.
REQ-027 Reset mid-WAIT SHALL abandon the command; a late eng_dend_i after reset SHALL be ignored.

Configuration
REQ-028 With PROOF_ADDSUB_CHK_EN defined, SHALL compute (A+B) mod p or (A-B) mod p from the issued operands and compare it with eng_datc_i on eng_dend_i in WAIT; a mismatch SHALL set chk_err_o.
REQ-029 Without PROOF_ADDSUB_CHK_EN, the checker SHALL be absent and chk_err_o SHALL be tied to 0.

Verification
REQ-030 p=97, r0=50, r1=60, add r0,r1->r2, engine model 3 cycles -> eng_dstr_o pulse, r2=13, done_o 6 cycles after pop.
REQ-031 p=97, r0=10, r1=20, sub r0,r1->r3 -> r3=87; then sub r1,r0->r1 -> r1=10.
REQ-032 Push 3 commands in 3 consecutive cycles while the first is executing -> cmd_rdy_o low once full, all 3 complete in order, 3 done_o pulses.
REQ-033 Engine never asserts eng_dend_i -> err_o=1 after 15 WAIT cycles, destination unchanged; err_clr_i -> err_o=0.
REQ-034 Host write r2=5 in the WB cycle of a command targeting r2 with result 13 -> r2=13.
REQ-035 With PROOF_ADDSUB_CHK_EN, engine returns 14 for a case expecting 13 -> chk_err_o=1; without the macro -> chk_err_o=0.

Source files
------------

// File: rtl/proof_addsub_seq.sv
// rtl/proof_addsub_seq.sv - sequencer feeding a modular add/sub engine from a 4x256 register file
// Optional result checker: define PROOF_ADDSUB_CHK_EN to enable it; otherwise chk_err_o is tied to 0.
module proof_addsub_seq #(
    parameter int unsigned TMO_CYC = 15
) (
    input  logic         clk_i,
    input  logic         arst_ni,
    input  logic         cmd_vld_i,
    output logic         cmd_rdy_o,
    input  logic         cmd_mode_i,
    input  logic [1:0]   cmd_sa_i,
    input  logic [1:0]   cmd_sb_i,
    input  logic [1:0]   cmd_dst_i,
    input  logic         wr_en_i,
    input  logic [1:0]   wr_addr_i,
    input  logic [255:0] wr_data_i,
    input  logic [1:0]   rd_addr_i,
    output logic [255:0] rd_data_o,
    input  logic [255:0] modp_i,
    output logic [255:0] eng_modp_o,
    output logic         eng_dstr_o,
    output logic         eng_mode_o,
    output logic [255:0] eng_data_o,
    output logic [255:0] eng_datb_o,
    input  logic         eng_dend_i,
    input  logic [255:0] eng_datc_i,
    output logic         done_o,
    output logic         busy_o,
    output logic         err_o,
    input  logic         err_clr_i,
    output logic         chk_err_o
);

    localparam int CW = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [255:0]   regs [4];

    // command FIFO: entries packed as {mode, sa, sb, dst}
    logic [6:0]     fifo_mem [2];
    logic           wptr;
    logic           rptr;
    logic [1:0]     count;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           pop;

    logic           cur_mode;
    logic [1:0]     cur_sa;
    logic [1:0]     cur_sb;
    logic [1:0]     cur_dst;
    logic [255:0]   op_a;
    logic [255:0]   op_b;
    logic [255:0]   res_q;
    logic [CW-1:0]  tmo_cnt;
    logic           tmo_hit;
    logic           err_q;

    assign fifo_full  = (count == 2'd2);
    assign fifo_empty = (count == 2'd0);
    assign pop        = (state == S_IDLE) && !fifo_empty;
    // a full FIFO that pops this cycle frees a slot for the incoming command
    assign cmd_rdy_o  = !fifo_full || pop;
    assign push       = cmd_vld_i && cmd_rdy_o;

    // a response on the timeout cycle itself still counts as a response
    assign tmo_hit    = (state == S_WAIT) && !eng_dend_i && (tmo_cnt == CW'(TMO_CYC - 1));

    assign rd_data_o  = regs[rd_addr_i];
    assign eng_modp_o = modp_i;
    assign err_o      = err_q;

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // FIFO storage, no reset needed since occupancy guards reads
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wptr] <= {cmd_mode_i, cmd_sa_i, cmd_sb_i, cmd_dst_i};
    end

    // state register
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!fifo_empty) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  begin
                if (eng_dend_i)   state_nxt = S_WB;
                else if (tmo_hit) state_nxt = S_IDLE;
            end
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // outputs: operands read live in ISSUE, held from latches through WAIT, zero otherwise
    always_comb begin
        eng_dstr_o = (state == S_ISSUE);
        eng_mode_o = 1'b0;
        eng_data_o = '0;
        eng_datb_o = '0;
        if (state == S_ISSUE) begin
            eng_mode_o = cur_mode;
            eng_data_o = regs[cur_sa];
            eng_datb_o = regs[cur_sb];
        end else if (state == S_WAIT) begin
            eng_mode_o = cur_mode;
            eng_data_o = op_a;
            eng_datb_o = op_b;
        end
        done_o = (state == S_WB) || tmo_hit;
        busy_o = (state != S_IDLE) || !fifo_empty;
    end

    // current command, operand snapshot, result latch and timeout counter
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cur_mode <= 1'b0;
            cur_sa   <= 2'd0;
            cur_sb   <= 2'd0;
            cur_dst  <= 2'd0;
            op_a     <= '0;
            op_b     <= '0;
            res_q    <= '0;
            tmo_cnt  <= '0;
        end else begin
            if (pop) {cur_mode, cur_sa, cur_sb, cur_dst} <= fifo_mem[rptr];
            if (state == S_ISSUE) begin
                op_a    <= regs[cur_sa];
                op_b    <= regs[cur_sb];
                tmo_cnt <= '0;
            end else if (state == S_WAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (state == S_WAIT && eng_dend_i) res_q <= eng_datc_i;
        end
    end

    // register file: writeback beats a host write to the same address
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (state == S_WB && cur_dst == 2'(i))
                    regs[i] <= res_q;
                else if (wr_en_i && wr_addr_i == 2'(i))
                    regs[i] <= wr_data_i;
            end
        end
    end

    // sticky timeout flag, set wins over clear
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni)       err_q <= 1'b0;
        else if (tmo_hit)   err_q <= 1'b1;
        else if (err_clr_i) err_q <= 1'b0;
    end

`ifdef PROOF_ADDSUB_CHK_EN
    logic [256:0] chk_sum;
    logic [256:0] chk_red;
    logic [255:0] chk_exp;
    logic         chk_err_q;

    // reference result from the held operands (operands assumed already reduced mod p)
    always_comb begin
        chk_sum = {1'b0, op_a} + {1'b0, op_b};
        chk_red = chk_sum - {1'b0, modp_i};
        chk_exp = '0;
        if (cur_mode) begin
            if (op_a >= op_b) chk_exp = op_a - op_b;
            else              chk_exp = op_a + modp_i - op_b;
        end else begin
            if (chk_sum >= {1'b0, modp_i}) chk_exp = chk_red[255:0];
            else                           chk_exp = chk_sum[255:0];
        end
    end

    // sticky result-check flag, set wins over clear
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni)
            chk_err_q <= 1'b0;
        else if (state == S_WAIT && eng_dend_i && eng_datc_i != chk_exp)
            chk_err_q <= 1'b1;
        else if (err_clr_i)
            chk_err_q <= 1'b0;
    end

    assign chk_err_o = chk_err_q;
`else
    assign chk_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_proof_addsub_seq.sv
// tb/tb_proof_addsub_seq.sv - directed self-checking bench for proof_addsub_seq
`timescale 1ns/1ps
module tb_proof_addsub_seq;

    logic         clk_i = 1'b0;
    logic         arst_ni;
    logic         cmd_vld_i;
    logic         cmd_rdy_o;
    logic         cmd_mode_i;
    logic [1:0]   cmd_sa_i;
    logic [1:0]   cmd_sb_i;
    logic [1:0]   cmd_dst_i;
    logic         wr_en_i;
    logic [1:0]   wr_addr_i;
    logic [255:0] wr_data_i;
    logic [1:0]   rd_addr_i;
    logic [255:0] rd_data_o;
    logic [255:0] modp_i;
    logic [255:0] eng_modp_o;
    logic         eng_dstr_o;
    logic         eng_mode_o;
    logic [255:0] eng_data_o;
    logic [255:0] eng_datb_o;
    logic         eng_dend_i;
    logic [255:0] eng_datc_i;
    logic         done_o;
    logic         busy_o;
    logic         err_o;
    logic         err_clr_i;
    logic         chk_err_o;

    int tests = 0;
    int fails = 0;

    // engine model controls
    logic         eng_en;
    logic         eng_bad;
    logic [1:0]   mdl_cnt;
    logic         mdl_dend;
    logic [255:0] mdl_datc;
    logic [255:0] mdl_res;
    logic         man_dend;
    logic [255:0] man_datc;

    assign eng_dend_i = mdl_dend | man_dend;
    assign eng_datc_i = man_dend ? man_datc : mdl_datc;

    proof_addsub_seq #(.TMO_CYC(15)) dut (
        .clk_i(clk_i), .arst_ni(arst_ni),
        .cmd_vld_i(cmd_vld_i), .cmd_rdy_o(cmd_rdy_o), .cmd_mode_i(cmd_mode_i),
        .cmd_sa_i(cmd_sa_i), .cmd_sb_i(cmd_sb_i), .cmd_dst_i(cmd_dst_i),
        .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
        .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .modp_i(modp_i), .eng_modp_o(eng_modp_o),
        .eng_dstr_o(eng_dstr_o), .eng_mode_o(eng_mode_o),
        .eng_data_o(eng_data_o), .eng_datb_o(eng_datb_o),
        .eng_dend_i(eng_dend_i), .eng_datc_i(eng_datc_i),
        .done_o(done_o), .busy_o(busy_o), .err_o(err_o),
        .err_clr_i(err_clr_i), .chk_err_o(chk_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [255:0] mod_op(input logic m, input logic [255:0] a,
                                            input logic [255:0] b, input logic [255:0] p);
        logic [256:0] s;
        if (m) begin
            if (a >= b) return a - b;
            return a + p - b;
        end
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, p}) s = s - {1'b0, p};
        return s[255:0];
    endfunction

    // engine: samples the start pulse, responds three edges later
    assign mdl_res = mod_op(eng_mode_o, eng_data_o, eng_datb_o, modp_i);
    always @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            mdl_cnt  <= 2'd0;
            mdl_dend <= 1'b0;
            mdl_datc <= '0;
        end else begin
            mdl_dend <= 1'b0;
            if (eng_dstr_o && eng_en) begin
                mdl_cnt  <= 2'd3;
                mdl_datc <= eng_bad ? mdl_res + 256'd1 : mdl_res;
            end else if (mdl_cnt != 2'd0) begin
                mdl_cnt <= mdl_cnt - 2'd1;
                if (mdl_cnt == 2'd1) mdl_dend <= 1'b1;
            end
        end
    end

    task automatic host_write(input logic [1:0] a, input logic [255:0] d);
        @(negedge clk_i);
        wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
        @(negedge clk_i);
        wr_en_i = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [255:0] d);
        rd_addr_i = a;
        #1;
        d = rd_data_o;
    endtask

    // push one command, wait for its done_o; cyc = negedges waited, -1 on expiry
    task automatic run_cmd(input logic m, input logic [1:0] sa, input logic [1:0] sb,
                           input logic [1:0] dst, output int cyc);
        @(negedge clk_i);
        cmd_vld_i = 1'b1; cmd_mode_i = m; cmd_sa_i = sa; cmd_sb_i = sb; cmd_dst_i = dst;
        @(negedge clk_i);
        cmd_vld_i = 1'b0;
        cyc = -1;
        for (int n = 0; n < 100; n++) begin
            if (done_o) begin cyc = n; break; end
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset;
        logic [255:0] d;
        arst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        read_reg(2'd0, d);
        tests++; if (cmd_rdy_o !== 1'b1) begin fails++; $display("FAIL rst_rdy got %b want 1", cmd_rdy_o); end
        tests++; if (busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 || chk_err_o !== 1'b0) begin
            fails++; $display("FAIL rst_flags got busy=%b done=%b err=%b chk=%b want 0", busy_o, done_o, err_o, chk_err_o); end
        tests++; if (eng_dstr_o !== 1'b0 || eng_data_o !== 256'd0 || eng_datb_o !== 256'd0) begin
            fails++; $display("FAIL rst_eng got dstr=%b a=%0d b=%0d want 0", eng_dstr_o, eng_data_o, eng_datb_o); end
        tests++; if (d !== 256'd0) begin fails++; $display("FAIL rst_rd got %0d want 0", d); end
        tests++; if (eng_modp_o !== 256'd97) begin fails++; $display("FAIL rst_modp got %0d want 97", eng_modp_o); end
        @(negedge clk_i);
        arst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_add;
        logic [255:0] d;
        int k;
        int dstr_extra;
        host_write(2'd0, 256'd50);
        host_write(2'd1, 256'd60);
        @(negedge clk_i);
        cmd_vld_i = 1'b1; cmd_mode_i = 1'b0; cmd_sa_i = 2'd0; cmd_sb_i = 2'd1; cmd_dst_i = 2'd2;
        @(negedge clk_i);
        cmd_vld_i = 1'b0;
        k = 0;
        while (!eng_dstr_o && k < 10) begin @(negedge clk_i); k++; end
        tests++; if (eng_dstr_o !== 1'b1) begin fails++; $display("FAIL add_dstr got %b want 1", eng_dstr_o); end
        tests++; if (eng_data_o !== 256'd50 || eng_datb_o !== 256'd60 || eng_mode_o !== 1'b0) begin
            fails++; $display("FAIL add_ops got a=%0d b=%0d m=%b want 50 60 0", eng_data_o, eng_datb_o, eng_mode_o); end
        k = 0; dstr_extra = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk_i);
            if (eng_dstr_o) dstr_extra++;
            if (n == 1) begin
                tests++; if (eng_data_o !== 256'd50 || eng_datb_o !== 256'd60) begin
                    fails++; $display("FAIL add_hold got a=%0d b=%0d want 50 60", eng_data_o, eng_datb_o); end
            end
            if (done_o) begin k = n; break; end
        end
        // ISSUE is cycle 1 after the pop, done_o lands in cycle 6
        tests++; if (k != 5) begin fails++; $display("FAIL add_latency got %0d want 5 cycles after dstr", k); end
        tests++; if (dstr_extra != 0) begin fails++; $display("FAIL add_dstr_once got %0d extra want 0", dstr_extra); end
        @(negedge clk_i);
        read_reg(2'd2, d);
        tests++; if (d !== 256'd13) begin fails++; $display("FAIL add_r2 got %0d want 13", d); end
        tests++; if (eng_data_o !== 256'd0 || busy_o !== 1'b0) begin
            fails++; $display("FAIL add_idle got a=%0d busy=%b want 0 0", eng_data_o, busy_o); end
    endtask

    task automatic test_sub;
        logic [255:0] d;
        int c;
        host_write(2'd0, 256'd10);
        host_write(2'd1, 256'd20);
        run_cmd(1'b1, 2'd0, 2'd1, 2'd3, c);
        tests++; if (c < 0) begin fails++; $display("FAIL sub1_done got timeout want done"); end
        @(negedge clk_i);
        read_reg(2'd3, d);
        tests++; if (d !== 256'd87) begin fails++; $display("FAIL sub1_r3 got %0d want 87", d); end
        run_cmd(1'b1, 2'd1, 2'd0, 2'd1, c);
        @(negedge clk_i);
        read_reg(2'd1, d);
        tests++; if (d !== 256'd10) begin fails++; $display("FAIL sub2_r1 got %0d want 10", d); end
        run_cmd(1'b0, 2'd1, 2'd1, 2'd1, c);
        @(negedge clk_i);
        read_reg(2'd1, d);
        tests++; if (d !== 256'd20) begin fails++; $display("FAIL alias_r1 got %0d want 20", d); end
    endtask

    task automatic test_back_to_back;
        logic [6:0]   list [4];
        logic [255:0] d;
        int i, ndone, last_done, gap, rdy_low;
        list[0] = {1'b0, 2'd0, 2'd1, 2'd2};
        list[1] = {1'b0, 2'd0, 2'd1, 2'd3};
        list[2] = {1'b0, 2'd3, 2'd3, 2'd3};
        list[3] = {1'b0, 2'd3, 2'd0, 2'd2};
        host_write(2'd0, 256'd1);
        host_write(2'd1, 256'd2);
        i = 0; ndone = 0; last_done = -1; gap = -1; rdy_low = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk_i);
            if (done_o) begin ndone++; last_done = cyc; end
            if (eng_dstr_o && last_done >= 0 && gap < 0) gap = cyc - last_done;
            if (i < 4) begin
                {cmd_mode_i, cmd_sa_i, cmd_sb_i, cmd_dst_i} = list[i];
                cmd_vld_i = 1'b1;
                if (cmd_rdy_o) i++;
                else rdy_low = 1;
            end else begin
                cmd_vld_i = 1'b0;
            end
            if (ndone == 4) break;
        end
        cmd_vld_i = 1'b0;
        tests++; if (rdy_low != 1) begin fails++; $display("FAIL b2b_rdy_low got %0d want 1", rdy_low); end
        tests++; if (ndone != 4) begin fails++; $display("FAIL b2b_done got %0d want 4", ndone); end
        tests++; if (gap != 2) begin fails++; $display("FAIL b2b_gap got %0d want 2", gap); end
        @(negedge clk_i);
        read_reg(2'd3, d);
        tests++; if (d !== 256'd6) begin fails++; $display("FAIL b2b_r3 got %0d want 6", d); end
        read_reg(2'd2, d);
        tests++; if (d !== 256'd7) begin fails++; $display("FAIL b2b_r2 got %0d want 7", d); end
    endtask

    task automatic test_wb_collision;
        logic [255:0] d;
        int seen;
        host_write(2'd0, 256'd50);
        host_write(2'd1, 256'd60);
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk_i);
            cmd_vld_i = 1'b1; cmd_mode_i = 1'b0; cmd_sa_i = 2'd0; cmd_sb_i = 2'd1;
            cmd_dst_i = (pass == 0) ? 2'd2 : 2'd3;
            @(negedge clk_i);
            cmd_vld_i = 1'b0;
            seen = 0;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk_i);
                if (done_o) begin
                    wr_en_i   = 1'b1;
                    wr_addr_i = (pass == 0) ? 2'd2 : 2'd1;
                    wr_data_i = (pass == 0) ? 256'd5 : 256'd99;
                    seen = 1;
                    break;
                end
            end
            @(negedge clk_i);
            wr_en_i = 1'b0;
            tests++; if (seen != 1) begin fails++; $display("FAIL coll_done pass %0d got none want done", pass); end
        end
        read_reg(2'd2, d);
        tests++; if (d !== 256'd13) begin fails++; $display("FAIL coll_same_r2 got %0d want 13", d); end
        read_reg(2'd3, d);
        tests++; if (d !== 256'd13) begin fails++; $display("FAIL coll_diff_r3 got %0d want 13", d); end
        read_reg(2'd1, d);
        tests++; if (d !== 256'd99) begin fails++; $display("FAIL coll_diff_r1 got %0d want 99", d); end
    endtask

    task automatic test_chk;
        logic [255:0] d;
        logic exp_chk;
        int c;
`ifdef PROOF_ADDSUB_CHK_EN
        exp_chk = 1'b1;
`else
        exp_chk = 1'b0;
`endif
        host_write(2'd1, 256'd60);
        eng_bad = 1'b1;
        run_cmd(1'b0, 2'd0, 2'd1, 2'd2, c);
        eng_bad = 1'b0;
        @(negedge clk_i);
        tests++; if (chk_err_o !== exp_chk) begin fails++; $display("FAIL chk_flag got %b want %b", chk_err_o, exp_chk); end
        read_reg(2'd2, d);
        tests++; if (d !== 256'd14) begin fails++; $display("FAIL chk_r2 got %0d want 14", d); end
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        tests++; if (chk_err_o !== 1'b0) begin fails++; $display("FAIL chk_clr got %b want 0", chk_err_o); end
    endtask

    task automatic test_timeout;
        logic [255:0] d;
        int k;
        eng_en = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            err_clr_i = (pass == 1);
            @(negedge clk_i);
            cmd_vld_i = 1'b1; cmd_mode_i = 1'b0; cmd_sa_i = 2'd0; cmd_sb_i = 2'd1; cmd_dst_i = 2'd2;
            @(negedge clk_i);
            cmd_vld_i = 1'b0;
            k = 0;
            while (!eng_dstr_o && k < 10) begin @(negedge clk_i); k++; end
            k = -1;
            for (int n = 1; n <= 40; n++) begin
                @(negedge clk_i);
                if (done_o) begin k = n; break; end
            end
            @(negedge clk_i);
            err_clr_i = 1'b0;
            if (pass == 0) begin
                tests++; if (k != 15) begin fails++; $display("FAIL tmo_cycles got %0d want 15", k); end
                tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL tmo_err got %b want 1", err_o); end
                tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL tmo_busy got %b want 0", busy_o); end
                read_reg(2'd2, d);
                tests++; if (d !== 256'd14) begin fails++; $display("FAIL tmo_dst got %0d want 14", d); end
                err_clr_i = 1'b1;
                @(negedge clk_i);
                err_clr_i = 1'b0;
                tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL tmo_clr got %b want 0", err_o); end
            end else begin
                tests++; if (err_o !== 1'b1) begin fails++; $display("FAIL tmo_set_wins got %b want 1", err_o); end
                err_clr_i = 1'b1;
                @(negedge clk_i);
                err_clr_i = 1'b0;
            end
        end
        eng_en = 1'b1;
    endtask

    task automatic test_reset_mid;
        logic [255:0] d;
        int k, dn;
        eng_en = 1'b0;
        @(negedge clk_i);
        cmd_vld_i = 1'b1; cmd_mode_i = 1'b0; cmd_sa_i = 2'd0; cmd_sb_i = 2'd1; cmd_dst_i = 2'd3;
        @(negedge clk_i);
        cmd_vld_i = 1'b0;
        k = 0;
        while (!eng_dstr_o && k < 10) begin @(negedge clk_i); k++; end
        repeat (3) @(negedge clk_i);
        arst_ni = 1'b0;
        #1;
        read_reg(2'd3, d);
        tests++; if (busy_o !== 1'b0 || cmd_rdy_o !== 1'b1 || eng_data_o !== 256'd0) begin
            fails++; $display("FAIL rmid_state got busy=%b rdy=%b a=%0d want 0 1 0", busy_o, cmd_rdy_o, eng_data_o); end
        tests++; if (d !== 256'd0) begin fails++; $display("FAIL rmid_regs got %0d want 0", d); end
        @(negedge clk_i);
        arst_ni = 1'b1;
        @(negedge clk_i);
        man_dend = 1'b1; man_datc = 256'd123;
        dn = 0;
        repeat (2) begin @(negedge clk_i); if (done_o) dn++; end
        man_dend = 1'b0;
        repeat (2) begin @(negedge clk_i); if (done_o) dn++; end
        read_reg(2'd3, d);
        tests++; if (dn != 0 || busy_o !== 1'b0) begin fails++; $display("FAIL rmid_late got done=%0d busy=%b want 0 0", dn, busy_o); end
        tests++; if (d !== 256'd0) begin fails++; $display("FAIL rmid_late_r3 got %0d want 0", d); end
        eng_en = 1'b1;
    endtask

    initial begin
        arst_ni = 1'b0; cmd_vld_i = 1'b0; cmd_mode_i = 1'b0; cmd_sa_i = '0; cmd_sb_i = '0; cmd_dst_i = '0;
        wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0; rd_addr_i = '0; modp_i = 256'd97;
        err_clr_i = 1'b0; eng_en = 1'b1; eng_bad = 1'b0; man_dend = 1'b0; man_datc = '0;
        test_reset;
        test_add;
        test_sub;
        test_back_to_back;
        test_wb_collision;
        test_chk;
        test_timeout;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
